// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: PC-select codes, FSM states,
// the canonical NOP and the mcause interrupt flag position.
package pipe_ctrl_pkg;

  localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SEL_BR    = 2'd1;
  localparam logic [1:0] PC_SEL_MTVEC = 2'd2;
  localparam logic [1:0] PC_SEL_MEPC  = 2'd3;

  // addi x0, x0, 0 -- what a flushed ID/EX register carries
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // mcause[31] marks an asynchronous (interrupt) cause
  localparam int MCAUSE_IRQ_BIT = 31;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_irq_ctrl_hazard_detect.sv
// Load-use hazard detector: the EX load's destination is a source of the
// instruction in ID, so ID must wait one cycle for the load data.
module hazard_detect (
  input  logic       i_ex_insn_vld,
  input  logic       i_ex_is_load,
  input  logic       i_ex_rd_wren,
  input  logic [4:0] i_ex_rd_addr,
  input  logic       i_id_insn_vld,
  input  logic [4:0] i_id_rs1_addr,
  input  logic [4:0] i_id_rs2_addr,
  input  logic       i_id_rs1_used,
  input  logic       i_id_rs2_used,
  output logic       o_load_use
);

  logic rs1_hit, rs2_hit, ex_ld;

  // x0 is hard-wired zero, so a load targeting it never blocks anyone
  always_comb begin
    ex_ld      = i_ex_insn_vld & i_ex_is_load & i_ex_rd_wren & (i_ex_rd_addr != 5'd0);
    rs1_hit    = i_id_rs1_used & (i_id_rs1_addr == i_ex_rd_addr);
    rs2_hit    = i_id_rs2_used & (i_id_rs2_addr == i_ex_rd_addr);
    o_load_use = ex_ld & i_id_insn_vld & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_irq_ctrl.sv
// Pipeline sequencer: stalls on load-use, redirects on branch/MRET, and
// enters the interrupt trap after draining the older instructions.
module pipe_hazard_irq_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYC = 2,
  parameter int IRQ_CAUSE = 11
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_if_pc,
  input  logic        i_id_insn_vld,
  input  logic [31:0] i_id_pc,
  input  logic [4:0]  i_id_rs1_addr,
  input  logic [4:0]  i_id_rs2_addr,
  input  logic        i_id_rs1_used,
  input  logic        i_id_rs2_used,
  input  logic        i_ex_insn_vld,
  input  logic [31:0] i_ex_pc,
  input  logic [4:0]  i_ex_rd_addr,
  input  logic        i_ex_rd_wren,
  input  logic        i_ex_is_load,
  input  logic        i_br_taken,
  input  logic        i_ex_mret,
  input  logic        i_irq_pending,
  input  logic        i_mie,
  output logic        o_pc_en,
  output logic [1:0]  o_pc_sel,
  output logic        o_if_id_en,
  output logic        o_if_id_flush,
  output logic        o_id_ex_en,
  output logic        o_id_ex_flush,
  output logic        o_ex_mem_flush,
  output logic        o_trap_valid,
  output logic [31:0] o_trap_epc,
  output logic [31:0] o_trap_cause,
  output logic        o_busy
);

  localparam logic [2:0]  CNT_INIT   = 3'(DRAIN_CYC - 1);
  localparam logic [30:0] CAUSE_CODE = 31'(IRQ_CAUSE);
  localparam logic [31:0] TRAP_CAUSE = 32'(CAUSE_CODE) | (32'd1 << MCAUSE_IRQ_BIT);

  ctrl_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d;
  logic        load_use;

  hazard_detect u_hazard (
    .i_ex_insn_vld (i_ex_insn_vld),
    .i_ex_is_load  (i_ex_is_load),
    .i_ex_rd_wren  (i_ex_rd_wren),
    .i_ex_rd_addr  (i_ex_rd_addr),
    .i_id_insn_vld (i_id_insn_vld),
    .i_id_rs1_addr (i_id_rs1_addr),
    .i_id_rs2_addr (i_id_rs2_addr),
    .i_id_rs1_used (i_id_rs1_used),
    .i_id_rs2_used (i_id_rs2_used),
    .o_load_use    (load_use)
  );

  // State, drain counter and captured return PC
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
      epc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
    end
  end

  // Next state and pipeline controls; reset forces a frozen, flushed pipe
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    epc_d          = epc_q;
    o_pc_en        = 1'b1;
    o_pc_sel       = PC_SEL_PLUS4;
    o_if_id_en     = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_en     = 1'b1;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_flush = 1'b0;
    o_trap_valid   = 1'b0;
    o_trap_epc     = epc_q;
    o_trap_cause   = TRAP_CAUSE;
    o_busy         = (state_q != ST_RUN);

    if (i_rst) begin
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_id_ex_en     = 1'b0;
      o_if_id_flush  = 1'b1;
      o_id_ex_flush  = 1'b1;
      o_ex_mem_flush = 1'b1;
      o_busy         = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (i_irq_pending && i_mie) begin
            // The oldest in-flight instruction not yet retired becomes mepc;
            // a branch/MRET in EX is squashed and replays after the handler.
            o_ex_mem_flush = 1'b1;
            o_id_ex_flush  = 1'b1;
            o_if_id_flush  = 1'b1;
            o_pc_en        = 1'b0;
            epc_d          = i_ex_insn_vld ? i_ex_pc :
                             i_id_insn_vld ? i_id_pc : i_if_pc;
            cnt_d          = CNT_INIT;
            state_d        = ST_DRAIN;
          end else if (i_ex_mret) begin
            o_pc_sel      = PC_SEL_MEPC;
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
          end else if (i_br_taken) begin
            o_pc_sel      = PC_SEL_BR;
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
          end else if (load_use) begin
            o_pc_en       = 1'b0;
            o_if_id_en    = 1'b0;
            o_id_ex_flush = 1'b1;
          end
        end
        ST_DRAIN: begin
          o_pc_en       = 1'b0;
          o_if_id_flush = 1'b1;
          o_id_ex_flush = 1'b1;
          if (cnt_q == 3'd0) state_d = ST_TRAP;
          else               cnt_d   = cnt_q - 3'd1;
        end
        ST_TRAP: begin
          o_trap_valid  = 1'b1;
          o_pc_sel      = PC_SEL_MTVEC;
          o_if_id_flush = 1'b1;
          o_id_ex_flush = 1'b1;
          state_d       = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_irq_ctrl.sv
// Bench for the pipeline sequencer: directed scenarios followed by random
// traffic, each cycle compared against a cycle-count reference model.
module tb_pipe_hazard_irq_ctrl;

  localparam int DRAIN_CYC = 2;
  localparam int IRQ_CAUSE = 11;

  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic [31:0] i_if_pc = '0, i_id_pc = '0, i_ex_pc = '0;
  logic        i_id_insn_vld = 0, i_id_rs1_used = 0, i_id_rs2_used = 0;
  logic [4:0]  i_id_rs1_addr = '0, i_id_rs2_addr = '0, i_ex_rd_addr = '0;
  logic        i_ex_insn_vld = 0, i_ex_rd_wren = 0, i_ex_is_load = 0;
  logic        i_br_taken = 0, i_ex_mret = 0, i_irq_pending = 0, i_mie = 0;
  logic        o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush;
  logic        o_ex_mem_flush, o_trap_valid, o_busy;
  logic [1:0]  o_pc_sel;
  logic [31:0] o_trap_epc, o_trap_cause;

  int checks = 0, failures = 0;

  // Reference state: cycles elapsed since interrupt acceptance (0 = running)
  int          m_phase = 0;
  logic [31:0] m_epc   = '0;

  pipe_hazard_irq_ctrl #(.DRAIN_CYC(DRAIN_CYC), .IRQ_CAUSE(IRQ_CAUSE)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_if_pc(i_if_pc),
    .i_id_insn_vld(i_id_insn_vld), .i_id_pc(i_id_pc),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
    .i_ex_insn_vld(i_ex_insn_vld), .i_ex_pc(i_ex_pc), .i_ex_rd_addr(i_ex_rd_addr),
    .i_ex_rd_wren(i_ex_rd_wren), .i_ex_is_load(i_ex_is_load),
    .i_br_taken(i_br_taken), .i_ex_mret(i_ex_mret),
    .i_irq_pending(i_irq_pending), .i_mie(i_mie),
    .o_pc_en(o_pc_en), .o_pc_sel(o_pc_sel), .o_if_id_en(o_if_id_en),
    .o_if_id_flush(o_if_id_flush), .o_id_ex_en(o_id_ex_en),
    .o_id_ex_flush(o_id_ex_flush), .o_ex_mem_flush(o_ex_mem_flush),
    .o_trap_valid(o_trap_valid), .o_trap_epc(o_trap_epc),
    .o_trap_cause(o_trap_cause), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit ref_load_use();
    bit hit1, hit2;
    hit1 = i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr);
    hit2 = i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr);
    return i_ex_insn_vld && i_ex_is_load && i_ex_rd_wren && (i_ex_rd_addr != 0)
           && i_id_insn_vld && (hit1 || hit2);
  endfunction

  // One clock: check outputs at the falling edge, advance the model, then
  // return 1ns after the next rising edge so the caller can drive inputs.
  task automatic cyc();
    logic pc_en, ifid_en, idex_en, ifid_f, idex_f, exmem_f, trap, busy;
    logic [1:0] sel;
    @(negedge i_clk);
    pc_en = 1; ifid_en = 1; idex_en = 1; ifid_f = 0; idex_f = 0; exmem_f = 0;
    trap = 0; busy = 0; sel = 2'd0;
    if (i_rst) begin
      pc_en = 0; ifid_en = 0; idex_en = 0; ifid_f = 1; idex_f = 1; exmem_f = 1;
      m_phase = 0; m_epc = '0;
    end else if (m_phase == 0) begin
      if (i_irq_pending && i_mie) begin
        exmem_f = 1; idex_f = 1; ifid_f = 1; pc_en = 0;
        m_epc   = i_ex_insn_vld ? i_ex_pc : (i_id_insn_vld ? i_id_pc : i_if_pc);
        m_phase = 1;
      end else if (i_ex_mret) begin
        sel = 2'd3; ifid_f = 1; idex_f = 1;
      end else if (i_br_taken) begin
        sel = 2'd1; ifid_f = 1; idex_f = 1;
      end else if (ref_load_use()) begin
        pc_en = 0; ifid_en = 0; idex_f = 1;
      end
    end else if (m_phase <= DRAIN_CYC) begin
      pc_en = 0; ifid_f = 1; idex_f = 1; busy = 1;
      m_phase++;
    end else begin
      trap = 1; sel = 2'd2; ifid_f = 1; idex_f = 1; busy = 1;
      m_phase = 0;
    end
    chk("pc_en",     32'(o_pc_en),        32'(pc_en));
    chk("pc_sel",    32'(o_pc_sel),       32'(sel));
    chk("if_id_en",  32'(o_if_id_en),     32'(ifid_en));
    chk("if_id_fl",  32'(o_if_id_flush),  32'(ifid_f));
    chk("id_ex_en",  32'(o_id_ex_en),     32'(idex_en));
    chk("id_ex_fl",  32'(o_id_ex_flush),  32'(idex_f));
    chk("ex_mem_fl", 32'(o_ex_mem_flush), 32'(exmem_f));
    chk("trap_vld",  32'(o_trap_valid),   32'(trap));
    chk("busy",      32'(o_busy),         32'(busy));
    if (trap) begin
      chk("trap_epc",   o_trap_epc,   m_epc);
      chk("trap_cause", o_trap_cause, 32'h8000_0000 | 32'(IRQ_CAUSE));
    end
    @(posedge i_clk); #1;
  endtask

  task automatic idle();
    i_id_insn_vld = 0; i_ex_insn_vld = 0; i_ex_is_load = 0; i_ex_rd_wren = 0;
    i_id_rs1_used = 0; i_id_rs2_used = 0; i_br_taken = 0; i_ex_mret = 0;
    i_irq_pending = 0; i_mie = 0;
  endtask

  task automatic set_lw(input logic [4:0] rd, input logic [4:0] rs1);
    i_ex_insn_vld = 1; i_ex_is_load = 1; i_ex_rd_wren = 1; i_ex_rd_addr = rd;
    i_id_insn_vld = 1; i_id_rs1_used = 1; i_id_rs1_addr = rs1;
  endtask

  initial begin
    // Reset values
    cyc(); cyc();
    i_rst = 0;
    cyc();

    // Load-use: one bubble, then free flow once EX moves on
    set_lw(5'd5, 5'd5); cyc();
    idle(); i_id_insn_vld = 1; cyc();

    // Load into x0 never stalls; taken branch overrides a load-use
    set_lw(5'd0, 5'd0); cyc();
    set_lw(5'd5, 5'd5); i_br_taken = 1; cyc();

    // Interrupt with valid EX: epc = EX pc
    idle(); i_ex_insn_vld = 1; i_ex_pc = 32'h100; i_mie = 1; i_irq_pending = 1;
    repeat (DRAIN_CYC + 3) cyc();

    // Interrupt with empty EX/ID: epc = IF pc; pending drops mid-drain
    idle(); i_if_pc = 32'h204; i_mie = 1; i_irq_pending = 1; cyc();
    i_irq_pending = 0; i_mie = 0;
    repeat (DRAIN_CYC + 2) cyc();

    // MRET alone, then MRET squashed by a same-cycle interrupt
    idle(); i_ex_insn_vld = 1; i_ex_mret = 1; i_ex_pc = 32'h300; cyc();
    i_mie = 1; i_irq_pending = 1; cyc();
    idle(); repeat (DRAIN_CYC + 1) cyc();

    // Asynchronous reset in DRAIN: busy drops immediately, no trap follows
    i_mie = 1; i_irq_pending = 1; i_ex_insn_vld = 1; cyc();
    idle();
    i_rst = 1; #1;
    chk("async_busy", 32'(o_busy),       32'd0);
    chk("async_trap", 32'(o_trap_valid), 32'd0);
    chk("async_pcen", 32'(o_pc_en),      32'd0);
    cyc(); cyc();
    i_rst = 0;
    repeat (DRAIN_CYC + 2) cyc();

    // Random traffic; small register range to make collisions common
    for (int n = 0; n < 3000; n++) begin
      i_rst         = ($urandom_range(0, 99) == 0);
      i_if_pc       = $urandom & 32'hFFFF_FFFC;
      i_id_pc       = $urandom & 32'hFFFF_FFFC;
      i_ex_pc       = $urandom & 32'hFFFF_FFFC;
      i_id_insn_vld = 1'($urandom);
      i_ex_insn_vld = 1'($urandom);
      i_id_rs1_addr = 5'($urandom_range(0, 3));
      i_id_rs2_addr = 5'($urandom_range(0, 3));
      i_ex_rd_addr  = 5'($urandom_range(0, 3));
      i_id_rs1_used = 1'($urandom);
      i_id_rs2_used = 1'($urandom);
      i_ex_rd_wren  = 1'($urandom);
      i_ex_is_load  = 1'($urandom);
      i_br_taken    = ($urandom_range(0, 5) == 0);
      i_ex_mret     = ($urandom_range(0, 9) == 0);
      i_irq_pending = ($urandom_range(0, 7) == 0);
      i_mie         = 1'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_irq_ctrl.md
Name: pipe_hazard_irq_ctrl

Overview:
Central sequencer for the 5-stage RV32 pipeline. It drives enable, flush and PC-select for the IF/ID, ID/EX and EX/MEM registers and the PC. It resolves load-use stalls, taken-branch/MRET redirects and external-interrupt entry. Interrupt entry uses a small FSM that drains older instructions before redirecting to the trap vector.

Parameters:
DRAIN_CYC, 2, cycles spent in DRAIN so MEM/WB instructions retire (range 1..7)
IRQ_CAUSE, 11, exception code reported for external interrupt (mcause[30:0])

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_if_pc  in  32  PC currently being fetched
i_id_insn_vld  in  1  IF/ID holds valid instruction
i_id_pc  in  32  PC in IF/ID
i_id_rs1_addr  in  5  rs1 index of ID instruction
i_id_rs2_addr  in  5  rs2 index of ID instruction
i_id_rs1_used  in  1  ID instruction reads rs1
i_id_rs2_used  in  1  ID instruction reads rs2
i_ex_insn_vld  in  1  ID/EX holds valid instruction
i_ex_pc  in  32  PC in ID/EX
i_ex_rd_addr  in  5  rd of EX instruction
i_ex_rd_wren  in  1  EX instruction writes rd
i_ex_is_load  in  1  EX instruction is a load
i_br_taken  in  1  EX branch/jump resolved taken
i_ex_mret  in  1  EX instruction is MRET
i_irq_pending  in  1  external interrupt pending (level)
i_mie  in  1  mstatus.MIE
o_pc_en  out  1  PC register update enable
o_pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = mtvec, 3 = mepc
o_if_id_en  out  1  IF/ID enable
o_if_id_flush  out  1  IF/ID load NOP (insn_vld = 0)
o_id_ex_en  out  1  ID/EX enable
o_id_ex_flush  out  1  ID/EX load NOP (instr 0x00000013, controls 0)
o_ex_mem_flush  out  1  squash EX instruction entering EX/MEM
o_trap_valid  out  1  1-cycle pulse: CSR writes mepc/mcause, clears MIE
o_trap_epc  out  32  mepc value, valid with o_trap_valid
o_trap_cause  out  32  mcause value, valid with o_trap_valid
o_busy  out  1  FSM not in RUN

Behaviour:
- State registers: FSM, 3-bit drain counter, epc latch, all reset async by i_rst. Control outputs are combinational from state and inputs.
- While i_rst = 1: state RUN, counter 0, epc 0.
  - Outputs: pc_en = if_id_en = id_ex_en = 0, all flushes = 1, pc_sel = 0, trap_valid = 0, busy = 0.
- FSM states: RUN, DRAIN, TRAP.
- load_use = i_ex_insn_vld & i_ex_is_load & i_ex_rd_wren & (i_ex_rd_addr != 0) & i_id_insn_vld & ((rs1_used & rs1 == rd) | (rs2_used & rs2 == rd)).
- irq_acc = RUN & i_irq_pending & i_mie.
- RUN defaults: all enables 1, flushes 0, pc_sel 0.
- RUN priority, first match wins:
  1. irq_acc:
     - o_ex_mem_flush = 1, id_ex_flush = 1, if_id_flush = 1, pc_en = 0.
     - epc latched in priority order: i_ex_pc if ex valid; else i_id_pc if id valid; else i_if_pc.
     - Next state DRAIN, counter = DRAIN_CYC-1.
     - An accepted irq squashes a same-cycle branch or MRET in EX; that instruction re-executes after the handler.
  2. i_ex_mret: pc_sel = 3, if_id_flush = 1, id_ex_flush = 1.
  3. i_br_taken: pc_sel = 1, if_id_flush = 1, id_ex_flush = 1. Overrides load_use.
  4. load_use: pc_en = 0, if_id_en = 0, id_ex_flush = 1 (one bubble). Re-evaluated every cycle.
- DRAIN:
  - pc_en = 0, if_id_flush = 1, id_ex_flush = 1, ex_mem_flush = 0, busy = 1.
  - Counter decrements each cycle; at 0, next state is TRAP.
  - Changes on i_irq_pending or i_mie are ignored (commitment is final).
- TRAP (one cycle):
  - o_trap_valid = 1, epc = latch, cause = {1'b1, IRQ_CAUSE[30:0]}.
  - pc_sel = 2, pc_en = 1, if_id_flush = 1, id_ex_flush = 1, busy = 1.
  - Next state RUN.
- Interrupt entry latency: acceptance to trap_valid = DRAIN_CYC+1 cycles. The first handler fetch occurs the cycle after TRAP.
- i_irq_pending asserted with i_mie = 0 has no effect. The CSR clears MIE on trap_valid, which blocks re-entry.
- i_rst asserted mid-DRAIN or TRAP returns to RUN immediately. No trap_valid is produced.
- rd = x0 never causes a stall.

Decomposition:
- Shared package pipe_ctrl_pkg: pc_sel encodings (PC_SEL_PLUS4/BR/MTVEC/MEPC), FSM state enum, NOP constant 0x00000013, mcause interrupt bit position.
- One sub-module, hazard_detect: the purely combinational load_use computation, reused later for forwarding checks.

Test Plan:
- EX lw x5 (valid, load, wren, rd = 5), ID add uses rs1 = 5 -> one cycle with pc_en = 0, if_id_en = 0, id_ex_flush = 1; next cycle all enables 1.
- EX lw with rd = 0, ID rs1 = 0 -> no stall; EX lw rd = 5 with br_taken = 1 -> pc_sel = 1, flushes, no stall.
- i_mie = 1, irq_pending = 1, EX pc = 0x100 valid -> ex_mem_flush that cycle; busy for 3 cycles; trap_valid on cycle 3 with epc = 0x100, cause = 0x8000000B, pc_sel = 2.
- irq with EX invalid, ID invalid, if_pc = 0x204 -> epc = 0x204; irq deasserted during DRAIN -> trap still taken.
- EX mret = 1 -> pc_sel = 3, if_id_flush = 1, id_ex_flush = 1; irq + mret in the same cycle -> trap path, epc = EX pc.
- i_rst pulsed during DRAIN -> busy = 0 asynchronously, no trap_valid, reset output values held until release.
